// File: rtl/arb_pkg.sv
// Shared defaults and grant-vector helpers for the requester-side arbiter tracker.
package arb_pkg;
    localparam int ARB_N      = 32;
    localparam int ARB_CNT_W  = 4;
    localparam int ARB_MAX_N  = 64;
    localparam int ARB_IDX_MW = $clog2(ARB_MAX_N);

    // Callers zero-extend their vector to ARB_MAX_N so one function serves any N.
    function automatic logic [ARB_IDX_MW-1:0] onehot_lsb_idx(input logic [ARB_MAX_N-1:0] v);
        logic [ARB_IDX_MW-1:0] idx;
        idx = '0;
        for (int i = ARB_MAX_N - 1; i >= 0; i--) begin
            if (v[i]) idx = ARB_IDX_MW'(i);
        end
        return idx;
    endfunction

    function automatic logic popcount_gt1(input logic [ARB_MAX_N-1:0] v);
        return |(v & (v - ARB_MAX_N'(1)));
    endfunction
endpackage

// File: rtl/arb_req_tracker_if.sv
// Client/arbiter-facing bus of the request tracker; slave is the tracker side.
interface arb_req_tracker_if #(parameter int N = 32);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     event_i;
    logic [N-1:0]     gnt_i;
    logic             clr_err_i;
    logic [N-1:0]     req_o;
    logic             gnt_vld_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic [N-1:0]     ovf_o;
    logic             err_spurious_o;
    logic             err_multi_o;

    modport slave (
        input  event_i, gnt_i, clr_err_i,
        output req_o, gnt_vld_o, gnt_idx_o, ovf_o, err_spurious_o, err_multi_o
    );
    modport master (
        output event_i, gnt_i, clr_err_i,
        input  req_o, gnt_vld_o, gnt_idx_o, ovf_o, err_spurious_o, err_multi_o
    );
endinterface

// File: rtl/arb_req_counter.sv
// Single-client saturating pending-item counter; simultaneous inc and dec cancel.
module arb_req_counter #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic cnt_nz,
    output logic ovf_set
);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full  = (r_cnt == MAX);
    assign cnt_nz  = (r_cnt != '0);
    assign ovf_set = inc & ~dec & w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   if (cnt_nz)  r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/arb_req_tracker.sv
// Turns client event pulses into held request lines, retires one item per legal grant,
// registers the winning index and flags grant-bus protocol violations.
module arb_req_tracker
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int CNT_W = ARB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    arb_req_tracker_if.slave  bus
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]         w_req;
    logic [N-1:0]         w_legal;
    logic [N-1:0]         w_ovf_set;
    logic [ARB_MAX_N-1:0] w_legal_ext;
    logic [ARB_MAX_N-1:0] w_gnt_ext;
    logic [ARB_IDX_MW-1:0] w_idx;
    logic                 w_spurious;
    logic                 w_multi;

    logic                 r_gnt_vld;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [N-1:0]         r_ovf;
    logic                 r_err_spurious;
    logic                 r_err_multi;

    for (genvar g = 0; g < N; g++) begin : g_cnt
        arb_req_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (bus.event_i[g]),
            .dec     (w_legal[g]),
            .cnt_nz  (w_req[g]),
            .ovf_set (w_ovf_set[g])
        );
    end

    // Grants are only honoured on lines we are actually requesting.
    assign w_legal    = bus.gnt_i & w_req;
    assign w_spurious = |(bus.gnt_i & ~w_req);

    always_comb begin
        w_legal_ext        = '0;
        w_gnt_ext          = '0;
        w_legal_ext[N-1:0] = w_legal;
        w_gnt_ext[N-1:0]   = bus.gnt_i;
    end

    assign w_idx   = onehot_lsb_idx(w_legal_ext);
    assign w_multi = popcount_gt1(w_gnt_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_vld      <= 1'b0;
            r_gnt_idx      <= '0;
            r_ovf          <= '0;
            r_err_spurious <= 1'b0;
            r_err_multi    <= 1'b0;
        end else begin
            r_gnt_vld <= |w_legal;
            if (|w_legal) r_gnt_idx <= w_idx[IDX_W-1:0];
            // A new error in the clear cycle survives the clear.
            r_ovf          <= (bus.clr_err_i ? '0   : r_ovf)          | w_ovf_set;
            r_err_spurious <= (bus.clr_err_i ? 1'b0 : r_err_spurious) | w_spurious;
            r_err_multi    <= (bus.clr_err_i ? 1'b0 : r_err_multi)    | w_multi;
        end
    end

    assign bus.req_o          = w_req;
    assign bus.gnt_vld_o      = r_gnt_vld;
    assign bus.gnt_idx_o      = r_gnt_idx;
    assign bus.ovf_o          = r_ovf;
    assign bus.err_spurious_o = r_err_spurious;
    assign bus.err_multi_o    = r_err_multi;
endmodule

// File: tb/tb_arb_req_tracker.sv
// Directed bench for arb_req_tracker: vector table plus hand sequences for saturation and async reset.
module tb_arb_req_tracker;
    localparam int N = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    arb_req_tracker_if #(.N(N)) bus();

    arb_req_tracker #(.N(N), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ev;
        logic [N-1:0] gnt;
        logic         clr;
        logic [N-1:0] exp_req;
        logic         exp_vld;
        logic [4:0]   exp_idx;
        logic         exp_spur;
        logic         exp_multi;
        logic [N-1:0] exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] ev, input logic [N-1:0] gnt, input logic clr);
        @(negedge clk);
        bus.event_i   = ev;
        bus.gnt_i     = gnt;
        bus.clr_err_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags_clear(input string tag);
        check({tag, ".req"},   64'(bus.req_o), 64'd0);
        check({tag, ".vld"},   64'(bus.gnt_vld_o), 64'd0);
        check({tag, ".spur"},  64'(bus.err_spurious_o), 64'd0);
        check({tag, ".multi"}, 64'(bus.err_multi_o), 64'd0);
        check({tag, ".ovf"},   64'(bus.ovf_o), 64'd0);
    endtask

    function automatic vec_t mk(logic [N-1:0] ev, logic [N-1:0] gnt, logic clr,
                                logic [N-1:0] req, logic vld, logic [4:0] idx,
                                logic spur, logic multi);
        vec_t v;
        v.ev = ev; v.gnt = gnt; v.clr = clr; v.exp_req = req; v.exp_vld = vld;
        v.exp_idx = idx; v.exp_spur = spur; v.exp_multi = multi; v.exp_ovf = '0;
        return v;
    endfunction

    localparam logic [N-1:0] B2 = 32'h1 << 2;
    localparam logic [N-1:0] B3 = 32'h1 << 3;
    localparam logic [N-1:0] B4 = 32'h1 << 4;
    localparam logic [N-1:0] B5 = 32'h1 << 5;
    localparam logic [N-1:0] B7 = 32'h1 << 7;

    initial begin
        checks = 0;
        failures = 0;
        bus.event_i = '0;
        bus.gnt_i = '0;
        bus.clr_err_i = 1'b0;

        //            ev        gnt       clr   req       vld   idx spur multi
        vecs[0]  = mk(B5,       '0,       1'b0, B5,       1'b0, 0, 1'b0, 1'b0);
        vecs[1]  = mk('0,       '0,       1'b0, B5,       1'b0, 0, 1'b0, 1'b0);
        vecs[2]  = mk('0,       B5,       1'b0, '0,       1'b1, 5, 1'b0, 1'b0);
        vecs[3]  = mk('0,       '0,       1'b0, '0,       1'b0, 5, 1'b0, 1'b0);
        vecs[4]  = mk('0,       B3,       1'b0, '0,       1'b0, 5, 1'b1, 1'b0);
        vecs[5]  = mk('0,       '0,       1'b1, '0,       1'b0, 5, 1'b0, 1'b0);
        vecs[6]  = mk(B2 | B7,  '0,       1'b0, B2 | B7,  1'b0, 5, 1'b0, 1'b0);
        vecs[7]  = mk('0,       B2 | B7,  1'b0, '0,       1'b1, 2, 1'b0, 1'b1);
        vecs[8]  = mk(B7,       '0,       1'b1, B7,       1'b0, 2, 1'b0, 1'b0);
        vecs[9]  = mk(B7,       B7,       1'b0, B7,       1'b1, 7, 1'b0, 1'b0);
        vecs[10] = mk('0,       B4,       1'b1, B7,       1'b0, 7, 1'b1, 1'b0);
        vecs[11] = mk('0,       B7,       1'b1, '0,       1'b1, 7, 1'b0, 1'b0);

        // Reset and idle
        rst_n = 1'b0;
        #12;
        check_flags_clear("reset");
        check("reset.idx", 64'(bus.gnt_idx_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) drive('0, '0, 1'b0);
        check_flags_clear("idle");

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ev, vecs[i].gnt, vecs[i].clr);
            check($sformatf("v%0d.req", i),   64'(bus.req_o),          64'(vecs[i].exp_req));
            check($sformatf("v%0d.vld", i),   64'(bus.gnt_vld_o),      64'(vecs[i].exp_vld));
            check($sformatf("v%0d.idx", i),   64'(bus.gnt_idx_o),      64'(vecs[i].exp_idx));
            check($sformatf("v%0d.spur", i),  64'(bus.err_spurious_o), 64'(vecs[i].exp_spur));
            check($sformatf("v%0d.multi", i), 64'(bus.err_multi_o),    64'(vecs[i].exp_multi));
            check($sformatf("v%0d.ovf", i),   64'(bus.ovf_o),          64'(vecs[i].exp_ovf));
        end

        // Saturation on client 0: 15 fill, 16th overflows
        for (int k = 1; k <= 16; k++) begin
            drive(32'h1, '0, 1'b0);
            check($sformatf("sat%0d.req0", k), 64'(bus.req_o[0]), 64'd1);
            check($sformatf("sat%0d.ovf0", k), 64'(bus.ovf_o[0]), (k == 16) ? 64'd1 : 64'd0);
        end
        drive('0, '0, 1'b0);
        check("sat.ovf_sticky", 64'(bus.ovf_o), 64'h1);
        drive('0, '0, 1'b1);
        check("sat.ovf_clr", 64'(bus.ovf_o), 64'h0);
        // At MAX, event plus grant: no overflow, count unchanged
        drive(32'h1, 32'h1, 1'b0);
        check("sat.evgnt_ovf", 64'(bus.ovf_o), 64'h0);
        check("sat.evgnt_vld", 64'(bus.gnt_vld_o), 64'd1);
        check("sat.evgnt_idx", 64'(bus.gnt_idx_o), 64'd0);
        // Drain: req low exactly after the 15th grant
        for (int k = 1; k <= 15; k++) begin
            drive('0, 32'h1, 1'b0);
            check($sformatf("drain%0d.req0", k), 64'(bus.req_o[0]), (k == 15) ? 64'd0 : 64'd1);
        end
        check("drain.spur", 64'(bus.err_spurious_o), 64'd0);
        // Event with grant at cnt=1 keeps the request up
        drive(32'h1, '0, 1'b0);
        drive(32'h1, 32'h1, 1'b0);
        check("cnt1.evgnt_req0", 64'(bus.req_o[0]), 64'd1);
        drive('0, 32'h1, 1'b0);
        check("cnt1.last_req0", 64'(bus.req_o[0]), 64'd0);

        // Async reset mid-operation
        drive((32'h1 << 1) | (32'h1 << 4) | (32'h1 << 9), '0, 1'b0);
        drive(32'h1 << 9, '0, 1'b0);
        drive('0, B3, 1'b0);
        drive('0, 32'h1 << 9, 1'b0);
        check("pre_rst.req", 64'(bus.req_o), 64'h212);
        check("pre_rst.vld", 64'(bus.gnt_vld_o), 64'd1);
        check("pre_rst.idx", 64'(bus.gnt_idx_o), 64'd9);
        check("pre_rst.spur", 64'(bus.err_spurious_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_flags_clear("async_rst");
        check("async_rst.idx", 64'(bus.gnt_idx_o), 64'd0);
        bus.event_i = '0;
        bus.gnt_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) drive('0, '0, 1'b0);
        check("post_rst.no_replay", 64'(bus.req_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
